// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and received-byte outputs of uart_rx
interface uart_rx_if;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Active;
    logic       o_Rx_Frame_Err;
    logic       o_Rx_Parity_Err;

    // master is the receiver itself; slave is the pin driver and byte consumer
    modport master (
        input  i_Rx_Serial,
        output o_Rx_DV, o_Rx_Byte, o_Rx_Active, o_Rx_Frame_Err, o_Rx_Parity_Err
    );
    modport slave (
        output i_Rx_Serial,
        input  o_Rx_DV, o_Rx_Byte, o_Rx_Active, o_Rx_Frame_Err, o_Rx_Parity_Err
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver; UART_RX_PARITY_EN selects 8E1
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic     i_Clock,
    input  logic     i_Rst_n,
    uart_rx_if.master rx
);
    localparam int            CW    = $clog2(CLKS_PER_BIT);
    localparam int            H     = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] H_M1  = CW'(H - 1);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    index_q, index_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          dv_q, dv_d;
    logic          active_q, active_d;
    logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic          perr_q, perr_d;
    logic          par_bad_q, par_bad_d;
`endif

    always_comb begin
        state_d  = state_q;
        sync1_d  = rx.i_Rx_Serial;
        sync2_d  = sync1_q;
        count_d  = count_q;
        index_d  = index_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        active_d = active_q;
        ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (!sync2_q) begin
                    state_d  = S_START;
                    active_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_START: begin
                // counter reaches H on this edge: mid-start-bit re-check
                if (count_q == H_M1) begin
                    count_d = '0;
                    index_d = '0;
                    if (!sync2_q) begin
                        state_d = S_DATA;
                    end else begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end
            S_DATA: begin
                if (count_q == LAST) begin
                    count_d          = '0;
                    shift_d[index_q] = sync2_q;
                    if (index_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        index_d = index_q + 3'd1;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (count_q == LAST) begin
                    count_d   = '0;
                    par_bad_d = sync2_q ^ (^shift_q);
                    state_d   = S_STOP;
                end else begin
                    count_d = count_q + ONE;
                end
            end
`endif
            S_STOP: begin
                if (count_q == LAST) begin
                    count_d = '0;
                    if (sync2_q) begin
                        // leave at the stop midpoint so back-to-back starts are caught
                        state_d  = S_IDLE;
                        active_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            byte_d = shift_q;
                            dv_d   = 1'b1;
                        end
`else
                        byte_d = shift_q;
                        dv_d   = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end
            S_BREAK: begin
                if (sync2_q) begin
                    state_d  = S_IDLE;
                    active_d = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            count_q   <= '0;
            index_q   <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            active_q  <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            count_q   <= count_d;
            index_q   <= index_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            active_q  <= active_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign rx.o_Rx_DV         = dv_q;
    assign rx.o_Rx_Byte       = byte_q;
    assign rx.o_Rx_Active     = active_q;
    assign rx.o_Rx_Frame_Err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx.o_Rx_Parity_Err = perr_q;
`else
    assign rx.o_Rx_Parity_Err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed table-driven bench for uart_rx at 4 and 8 clocks per bit
module tb_uart_rx;
    logic clk;
    logic rst_n;

    uart_rx_if rx4();
    uart_rx_if rx8();

    uart_rx #(.CLKS_PER_BIT(4)) u4 (.i_Clock(clk), .i_Rst_n(rst_n), .rx(rx4.master));
    uart_rx #(.CLKS_PER_BIT(8)) u8 (.i_Clock(clk), .i_Rst_n(rst_n), .rx(rx8.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         dv4 = 0, ferr4 = 0, perr4 = 0, dv4_cyc = 0;
    int         dv8 = 0, ferr8 = 0, act8_seen = 0;
    logic [7:0] q4[$];

    always @(negedge clk) begin
        if (rx4.o_Rx_DV) begin
            dv4++;
            dv4_cyc = cyc;
            q4.push_back(rx4.o_Rx_Byte);
        end
        if (rx4.o_Rx_Frame_Err)  ferr4++;
        if (rx4.o_Rx_Parity_Err) perr4++;
        if (rx8.o_Rx_DV)         dv8++;
        if (rx8.o_Rx_Frame_Err)  ferr8++;
        if (rx8.o_Rx_Active)     act8_seen++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // drive a line level for n clocks; always returns 1 time unit after a rising edge
    task automatic line(input bit sel8, input bit v, input int n);
        if (sel8) rx8.i_Rx_Serial = v;
        else      rx4.i_Rx_Serial = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input bit sel8, input logic [7:0] d, input bit stop, input bit par_flip);
        int cpb;
        cpb = sel8 ? 8 : 4;
        line(sel8, 1'b0, cpb);
        for (int i = 0; i < 8; i++) line(sel8, d[i], cpb);
`ifdef UART_RX_PARITY_EN
        line(sel8, (^d) ^ par_flip, cpb);
`endif
        line(sel8, stop, cpb);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         exp_dv;
        int         exp_ferr;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         d_dv, d_fe, d_pe, base, t0;
        logic [7:0] prev;

        vecs[0] = '{8'hA3, 1'b1, 1, 0, 8'hA3};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'h55, 1'b1, 1, 0, 8'h55};
        vecs[4] = '{8'h3C, 1'b0, 0, 1, 8'h55};
        vecs[5] = '{8'h81, 1'b1, 1, 0, 8'h81};

        rst_n = 1'b0;
        rx4.i_Rx_Serial = 1'b1;
        rx8.i_Rx_Serial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dv",     int'(rx4.o_Rx_DV), 0);
        check("reset_byte",   int'(rx4.o_Rx_Byte), 0);
        check("reset_active", int'(rx4.o_Rx_Active), 0);
        check("reset_ferr",   int'(rx4.o_Rx_Frame_Err), 0);
        check("reset_perr",   int'(rx4.o_Rx_Parity_Err), 0);
        rst_n = 1'b1;
        line(1'b0, 1'b1, 8);

        // first byte: latency from the start edge to the DV strobe
        t0 = cyc;
        d_dv = dv4;
        frame(1'b0, 8'hA3, 1'b1, 1'b0);
        line(1'b0, 1'b1, 8);
        check("latency_dv_count", dv4 - d_dv, 1);
        check("latency_in_window",
              int'((dv4_cyc - t0) >= 40 && (dv4_cyc - t0) <= 42), 1);

        for (int i = 0; i < 6; i++) begin
            d_dv = dv4; d_fe = ferr4; d_pe = perr4;
            frame(1'b0, vecs[i].data, vecs[i].stop, 1'b0);
            line(1'b0, 1'b1, 8);
            check($sformatf("vec%0d_dv", i),   dv4 - d_dv, vecs[i].exp_dv);
            check($sformatf("vec%0d_ferr", i), ferr4 - d_fe, vecs[i].exp_ferr);
            check($sformatf("vec%0d_perr", i), perr4 - d_pe, 0);
            check($sformatf("vec%0d_byte", i), int'(rx4.o_Rx_Byte), int'(vecs[i].exp_byte));
        end

        // back-to-back frames with no idle time between stop and next start
        base = q4.size();
        frame(1'b0, 8'h00, 1'b1, 1'b0);
        frame(1'b0, 8'hFF, 1'b1, 1'b0);
        frame(1'b0, 8'h55, 1'b1, 1'b0);
        line(1'b0, 1'b1, 8);
        check("b2b_count", q4.size() - base, 3);
        if (q4.size() - base == 3) begin
            check("b2b_byte0", int'(q4[base]),     8'h00);
            check("b2b_byte1", int'(q4[base + 1]), 8'hFF);
            check("b2b_byte2", int'(q4[base + 2]), 8'h55);
        end

        // one-cycle glitch on the 8-clock receiver
        act8_seen = 0;
        d_dv = dv8; d_fe = ferr8;
        line(1'b1, 1'b0, 1);
        line(1'b1, 1'b1, 20);
        check("glitch_active_seen", int'(act8_seen > 0), 1);
        check("glitch_no_dv",       dv8 - d_dv, 0);
        check("glitch_no_ferr",     ferr8 - d_fe, 0);
        check("glitch_idle_after",  int'(rx8.o_Rx_Active), 0);
        d_dv = dv8;
        frame(1'b1, 8'h5A, 1'b1, 1'b0);
        line(1'b1, 1'b1, 16);
        check("u8_after_glitch_dv",   dv8 - d_dv, 1);
        check("u8_after_glitch_byte", int'(rx8.o_Rx_Byte), 8'h5A);

        // framing error followed by a long break
        prev = rx4.o_Rx_Byte;
        d_dv = dv4; d_fe = ferr4;
        frame(1'b0, 8'h3C, 1'b0, 1'b0);
        line(1'b0, 1'b0, 50);
        check("break_active_held", int'(rx4.o_Rx_Active), 1);
        line(1'b0, 1'b1, 8);
        check("break_one_ferr", ferr4 - d_fe, 1);
        check("break_no_dv",    dv4 - d_dv, 0);
        check("break_byte_kept", int'(rx4.o_Rx_Byte), int'(prev));
        d_dv = dv4;
        frame(1'b0, 8'h81, 1'b1, 1'b0);
        line(1'b0, 1'b1, 8);
        check("after_break_dv",   dv4 - d_dv, 1);
        check("after_break_byte", int'(rx4.o_Rx_Byte), 8'h81);

        // reset asserted during data bit 4
        line(1'b0, 1'b0, 4);
        for (int i = 0; i < 4; i++) line(1'b0, 1'(8'h7E >> i), 4);
        rx4.i_Rx_Serial = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_active", int'(rx4.o_Rx_Active), 0);
        check("midrst_byte",   int'(rx4.o_Rx_Byte), 0);
        check("midrst_dv",     int'(rx4.o_Rx_DV), 0);
        rx4.i_Rx_Serial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        line(1'b0, 1'b1, 12);
        check("midrst_idle", int'(rx4.o_Rx_Active), 0);
        d_dv = dv4;
        frame(1'b0, 8'h7E, 1'b1, 1'b0);
        line(1'b0, 1'b1, 8);
        check("after_rst_dv",   dv4 - d_dv, 1);
        check("after_rst_byte", int'(rx4.o_Rx_Byte), 8'h7E);

`ifdef UART_RX_PARITY_EN
        d_dv = dv4; d_pe = perr4;
        frame(1'b0, 8'hA3, 1'b1, 1'b0);
        line(1'b0, 1'b1, 8);
        check("par_good_dv",   dv4 - d_dv, 1);
        check("par_good_perr", perr4 - d_pe, 0);
        check("par_good_byte", int'(rx4.o_Rx_Byte), 8'hA3);
        d_dv = dv4; d_pe = perr4;
        frame(1'b0, 8'hA3, 1'b1, 1'b1);
        line(1'b0, 1'b1, 8);
        check("par_bad_dv",   dv4 - d_dv, 0);
        check("par_bad_perr", perr4 - d_pe, 1);
`else
        check("no_parity_strobe_ever", perr4, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive half of the UART link, the counterpart of `uart_tx`. It oversamples `i_Rx_Serial` with the system clock, locates the middle of each bit, and reassembles 8N1 frames (LSB first) into bytes. Each received byte is presented on `o_Rx_Byte` with a one-cycle `o_Rx_DV` strobe. The block sits between the board RX pin and the accelerator command path.

## Interface

- `CLKS_PER_BIT`, 87, system clocks per serial bit; legal range ≥ 4.
- `i_Clock`  in  1  system clock; all logic is on the rising edge.
- `i_Rst_n`  in  1  asynchronous, active-low reset.
- `i_Rx_Serial`  in  1  asynchronous serial line; idles high.
- `o_Rx_DV`  out  1  one-cycle strobe; `o_Rx_Byte` is valid in that cycle.
- `o_Rx_Byte`  out  8  last good byte; held until the next `o_Rx_DV`.
- `o_Rx_Active`  out  1  high while a frame is being received.
- `o_Rx_Frame_Err`  out  1  one-cycle strobe when the stop bit is sampled low.
- `o_Rx_Parity_Err`  out  1  one-cycle strobe on a parity mismatch; tied to 0 unless `UART_RX_PARITY_EN` is defined.

## Operation

- **Input synchronizer:** two-flop synchronizer on `i_Rx_Serial`. Both flops reset to 1. All decisions use the second flop (`r_Rx`).
- **Definitions:** H = (CLKS_PER_BIT-1)/2, integer division. The bit counter is `$clog2(CLKS_PER_BIT)` bits wide and is cleared at every bit boundary.
- **IDLE:** wait for `r_Rx`=0, then go to START with the counter at 0.
- **START:** at count H, re-check `r_Rx`.
  - If still 0: go to DATA with bit index 0.
  - If 1: treat as a glitch and return to IDLE with no output.
- **DATA:** every CLKS_PER_BIT cycles, sample `r_Rx` into shift bit [index], LSB first.
  - After bit 7, go to PARITY (when compiled in), otherwise to STOP.
- **PARITY:** one bit period later, sample the parity bit and compare it with the XOR of the 8 data bits (even parity).
- **STOP:** one bit period later, sample the stop bit.
  - Stop=1 and no parity error: load `o_Rx_Byte`, pulse `o_Rx_DV`, go to IDLE.
  - Stop=1 with parity error: pulse `o_Rx_Parity_Err`, leave `o_Rx_Byte` unchanged, go to IDLE.
  - Stop=0: pulse `o_Rx_Frame_Err`, leave `o_Rx_Byte` unchanged, go to BREAK. No DV is issued for a frame in error.
- **BREAK:** wait for `r_Rx`=1, then go to IDLE. A held-low line (break condition) produces exactly one `o_Rx_Frame_Err` and never re-triggers START.
- **Back-to-back frames:** IDLE is re-entered at the stop-bit midpoint, so a start edge arriving half a bit later is accepted with zero idle time between frames.
- **`o_Rx_Active`:** high in START, DATA, PARITY, STOP and BREAK; low only in IDLE.

## Timing

- **Reset values:** `o_Rx_DV`=0, `o_Rx_Byte`=8'h00, `o_Rx_Active`=0, both error strobes=0, state IDLE, synchronizer=1.
- **Reset mid-frame:** outputs clear immediately; the partial frame is discarded. After release, the next falling edge starts a fresh frame.
- **Sample points:** let E be the clock edge at which IDLE first sees `r_Rx`=0. E occurs 2 cycles after the pin falls.
  - Start re-check: edge E+H.
  - Data bit n: edge E+H+(n+1)·CLKS_PER_BIT.
  - Parity: edge E+H+9·CLKS_PER_BIT.
  - Stop: edge E+H+9·CLKS_PER_BIT without parity, or E+H+10·CLKS_PER_BIT with parity.
- **Strobes:** `o_Rx_DV`, `o_Rx_Frame_Err` and `o_Rx_Parity_Err` are registered. Each is high for exactly the one cycle following the stop-sample edge, and at most one of them is high per frame.
- **`o_Rx_Active`:** rises the cycle after E and falls in the same cycle as the strobe.
- **Throughput:** one byte per 10 bit times (11 with parity). No input flow control exists; the consumer must take `o_Rx_Byte` before the next DV.

## Configuration

- **`UART_RX_PARITY_EN`:**
  - Defined: frames are 8E1. The PARITY state is compiled in and `o_Rx_Parity_Err` is driven as described above.
  - Undefined: frames are 8N1. The PARITY state is absent and `o_Rx_Parity_Err` is constant 0. Port list is identical in both builds.

## Test plan

- **Single byte:** CLKS_PER_BIT=4, drive 8'hA3 as 8N1 (start, 1,1,0,0,0,1,0,1, stop) → one `o_Rx_DV` pulse with `o_Rx_Byte`=8'hA3, 40 to 42 cycles after the start edge; no error strobes.
- **Loopback, back-to-back:** `uart_tx` feeding `uart_rx`, same CLKS_PER_BIT=4, bytes 8'h00, 8'hFF, 8'h55 with no idle gap → three DV pulses carrying those values in order.
- **Glitch rejection:** pin low for 1 cycle then high, CLKS_PER_BIT=8 → `o_Rx_Active` pulses, no DV, no error, block returns to IDLE.
- **Framing error / break:** 8'h3C frame with stop bit 0, then line held low for 50 cycles → exactly one `o_Rx_Frame_Err`, `o_Rx_Byte` keeps its previous value, next good frame 8'h81 is received correctly.
- **Reset mid-frame:** assert `i_Rst_n`=0 at data bit 4 for 3 cycles → all outputs 0 asynchronously; next frame 8'h7E is received with DV and correct data.
- **Parity (UART_RX_PARITY_EN defined):** 8'hA3 with parity bit 0 → DV with 8'hA3; same byte with parity bit 1 → `o_Rx_Parity_Err` pulse, no DV.
